// File: rtl/axis_boxcar_decimator.sv
// Boxcar decimator: averages blocks of 2^k signed AXI-Stream samples and presents
// each block mean in a single output register, counting results lost to overrun.
module axis_boxcar_decimator #(
   parameter int S_AXIS_DATA_WIDTH = 32,
   parameter int M_AXIS_DATA_WIDTH = 32,
   parameter int LOG2_NMAX         = 8
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [S_AXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                         S_AXIS_tvalid,
   input  logic [3:0]                   decim_log2,
   input  logic                         clear,
   output logic [M_AXIS_DATA_WIDTH-1:0] M_AXIS_tdata,
   output logic                         M_AXIS_tvalid,
   input  logic                         M_AXIS_tready,
   output logic [15:0]                  overrun_count
);

   localparam int ACC_W = S_AXIS_DATA_WIDTH + LOG2_NMAX;
   localparam int CNT_W = LOG2_NMAX + 1;

   logic signed [ACC_W-1:0]             acc;
   logic [CNT_W-1:0]                    count;
   logic [3:0]                          blk_exp;
   logic [3:0]                          req_exp;
   logic [3:0]                          eff_exp;
   logic [CNT_W-1:0]                    block_len;
   logic signed [ACC_W-1:0]             sample_ext;
   logic signed [ACC_W-1:0]             sum;
   logic signed [M_AXIS_DATA_WIDTH-1:0] mean;
   logic                                accept;
   logic                                last;
   logic                                load;

   // The first sample of a block uses the live exponent; later ones use the latched copy.
   assign req_exp    = (int'(decim_log2) > LOG2_NMAX) ? 4'(LOG2_NMAX) : decim_log2;
   assign eff_exp    = (count == '0) ? req_exp : blk_exp;
   assign block_len  = CNT_W'(1) << eff_exp;
   assign sample_ext = {{LOG2_NMAX{S_AXIS_tdata[S_AXIS_DATA_WIDTH-1]}}, S_AXIS_tdata};
   assign sum        = acc + sample_ext;
   assign mean       = M_AXIS_DATA_WIDTH'(sum >>> eff_exp);
   assign accept     = S_AXIS_tvalid && !clear;
   assign last       = (count + CNT_W'(1)) == block_len;
   assign load       = accept && last;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc     <= '0;
         count   <= '0;
         blk_exp <= '0;
      end else if (clear) begin
         acc   <= '0;
         count <= '0;
      end else if (S_AXIS_tvalid) begin
         if (count == '0) begin
            blk_exp <= req_exp;
         end
         if (last) begin
            acc   <= '0;
            count <= '0;
         end else begin
            acc   <= sum;
            count <= count + CNT_W'(1);
         end
      end
   end

   // A new result always wins; it only counts as an overrun if the old one was never taken.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         M_AXIS_tdata  <= '0;
         M_AXIS_tvalid <= 1'b0;
         overrun_count <= '0;
      end else if (load) begin
         M_AXIS_tdata  <= mean;
         M_AXIS_tvalid <= 1'b1;
         if (M_AXIS_tvalid && !M_AXIS_tready && overrun_count != 16'hFFFF) begin
            overrun_count <= overrun_count + 16'd1;
         end
      end else if (M_AXIS_tvalid && M_AXIS_tready) begin
         M_AXIS_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_boxcar_decimator.sv
// Self-checking bench for axis_boxcar_decimator: vector table, directed corner
// sequences and a randomized run against a queue-based block-mean model.
module tb_axis_boxcar_decimator;

   localparam int LOG2_NMAX = 8;

   logic               aclk;
   logic               aresetn;
   logic signed [31:0] s_tdata;
   logic               s_tvalid;
   logic [3:0]         decim_log2;
   logic               clear;
   logic [31:0]        m_tdata;
   logic               m_tvalid;
   logic               m_tready;
   logic [15:0]        overrun_count;

   int n_compared;
   int n_mismatched;

   axis_boxcar_decimator #(
      .S_AXIS_DATA_WIDTH(32),
      .M_AXIS_DATA_WIDTH(32),
      .LOG2_NMAX(LOG2_NMAX)
   ) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .S_AXIS_tdata(s_tdata),
      .S_AXIS_tvalid(s_tvalid),
      .decim_log2(decim_log2),
      .clear(clear),
      .M_AXIS_tdata(m_tdata),
      .M_AXIS_tvalid(m_tvalid),
      .M_AXIS_tready(m_tready),
      .overrun_count(overrun_count)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: samples of the open block are kept in a queue and averaged
   // with floor division once the queue holds 2^k of them.
   longint mq[$];
   int     m_exp;
   logic   m_vld;
   longint m_data;
   int     m_over;

   function automatic longint floor_div(input longint num, input longint den);
      longint q;
      q = num / den;
      if ((num % den != 0) && (num < 0)) q = q - 1;
      return q;
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_exp  = 0;
      m_vld  = 1'b0;
      m_data = 0;
      m_over = 0;
   endfunction

   function automatic void model_edge(input logic vld, input longint data, input int dlog,
                                      input logic clr, input logic rdy);
      logic   load;
      longint total;
      longint avg;
      load  = 1'b0;
      avg   = 0;
      total = 0;
      if (clr) begin
         mq.delete();
      end else if (vld) begin
         if (mq.size() == 0) m_exp = (dlog > LOG2_NMAX) ? LOG2_NMAX : dlog;
         mq.push_back(data);
         if (mq.size() == (1 << m_exp)) begin
            foreach (mq[k]) total += mq[k];
            avg  = floor_div(total, longint'(1) << m_exp);
            mq.delete();
            load = 1'b1;
         end
      end
      if (load) begin
         if (m_vld && !rdy && m_over < 65535) m_over++;
         m_vld  = 1'b1;
         m_data = avg;
      end else if (m_vld && rdy) begin
         m_vld = 1'b0;
      end
   endfunction

   task automatic apply_stimulus(input logic vld, input logic signed [31:0] data,
                                 input logic [3:0] dlog, input logic clr, input logic rdy);
      s_tvalid   = vld;
      s_tdata    = data;
      decim_log2 = dlog;
      clear      = clr;
      m_tready   = rdy;
      model_edge(vld, longint'(data), int'(dlog), clr, rdy);
      @(posedge aclk);
      #1;
   endtask

   task automatic check_output(input string name, input logic exp_vld, input longint exp_data,
                               input int exp_over);
      n_compared++;
      if (m_tvalid !== exp_vld || longint'($signed(m_tdata)) != exp_data ||
          int'(overrun_count) != exp_over) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got tvalid=%0b tdata=%0d overrun=%0d, expected tvalid=%0b tdata=%0d overrun=%0d",
                  name, m_tvalid, $signed(m_tdata), overrun_count, exp_vld, exp_data, exp_over);
      end
   endtask

   typedef struct {
      logic               vld;
      logic signed [31:0] data;
      logic [3:0]         dlog;
      logic               clr;
      logic               rdy;
      logic               exp_vld;
      logic signed [31:0] exp_data;
      int                 exp_over;
   } vec_t;

   vec_t vecs[$];

   initial begin
      n_compared   = 0;
      n_mismatched = 0;

      // 4,8,12,16 -> 10; floor means of negative pairs; N=1 pass-through with overruns
      vecs.push_back('{1'b1,  32'sd4,  4'd2, 1'b0, 1'b1, 1'b0,  32'sd0, 0});
      vecs.push_back('{1'b1,  32'sd8,  4'd2, 1'b0, 1'b1, 1'b0,  32'sd0, 0});
      vecs.push_back('{1'b1,  32'sd12, 4'd2, 1'b0, 1'b1, 1'b0,  32'sd0, 0});
      vecs.push_back('{1'b1,  32'sd16, 4'd2, 1'b0, 1'b1, 1'b1,  32'sd10, 0});
      vecs.push_back('{1'b0,  32'sd0,  4'd2, 1'b0, 1'b1, 1'b0,  32'sd10, 0});
      vecs.push_back('{1'b1, -32'sd3,  4'd1, 1'b0, 1'b1, 1'b0,  32'sd10, 0});
      vecs.push_back('{1'b1, -32'sd4,  4'd1, 1'b0, 1'b1, 1'b1, -32'sd4, 0});
      vecs.push_back('{1'b1, -32'sd3,  4'd1, 1'b0, 1'b1, 1'b0, -32'sd4, 0});
      vecs.push_back('{1'b1, -32'sd2,  4'd1, 1'b0, 1'b1, 1'b1, -32'sd3, 0});
      vecs.push_back('{1'b0,  32'sd0,  4'd1, 1'b0, 1'b1, 1'b0, -32'sd3, 0});
      vecs.push_back('{1'b1,  32'sd1,  4'd0, 1'b0, 1'b0, 1'b1,  32'sd1, 0});
      vecs.push_back('{1'b1,  32'sd2,  4'd0, 1'b0, 1'b0, 1'b1,  32'sd2, 1});
      vecs.push_back('{1'b1,  32'sd3,  4'd0, 1'b0, 1'b0, 1'b1,  32'sd3, 2});
      vecs.push_back('{1'b0,  32'sd0,  4'd0, 1'b0, 1'b1, 1'b0,  32'sd3, 2});

      s_tvalid   = 1'b0;
      s_tdata    = '0;
      decim_log2 = '0;
      clear      = 1'b0;
      m_tready   = 1'b0;
      aresetn    = 1'b0;
      model_reset();
      repeat (2) @(posedge aclk);
      #1;
      check_output("reset_state", 1'b0, 0, 0);
      aresetn = 1'b1;

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].vld, vecs[i].data, vecs[i].dlog, vecs[i].clr, vecs[i].rdy);
         check_output($sformatf("vec%0d", i), vecs[i].exp_vld, longint'(vecs[i].exp_data),
                      vecs[i].exp_over);
      end

      // clear discards five samples plus the one presented with it
      for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 32'(100 + i), 4'd3, 1'b0, 1'b0);
      check_output("clr_partial", 1'b0, 3, 2);
      apply_stimulus(1'b1, 32'sd999, 4'd3, 1'b1, 1'b0);
      check_output("clr_edge", 1'b0, 3, 2);
      for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 32'h7FFFFFFF, 4'd3, 1'b0, 1'b0);
      check_output("clr_seven", 1'b0, 3, 2);
      apply_stimulus(1'b1, 32'h7FFFFFFF, 4'd3, 1'b0, 1'b0);
      check_output("clr_max_mean", 1'b1, 64'h7FFFFFFF, 2);
      apply_stimulus(1'b1, 32'sd5, 4'd3, 1'b1, 1'b0);
      check_output("clr_keeps_out", 1'b1, 64'h7FFFFFFF, 2);
      apply_stimulus(1'b0, 32'sd0, 4'd3, 1'b0, 1'b1);
      check_output("clr_drain", 1'b0, 64'h7FFFFFFF, 2);

      // exponent change mid-block applies from the next block only
      apply_stimulus(1'b1, 32'sd1, 4'd2, 1'b0, 1'b1);
      apply_stimulus(1'b1, 32'sd2, 4'd2, 1'b0, 1'b1);
      apply_stimulus(1'b1, 32'sd3, 4'd1, 1'b0, 1'b1);
      check_output("exp_hold_3", 1'b0, 64'h7FFFFFFF, 2);
      apply_stimulus(1'b1, 32'sd4, 4'd1, 1'b0, 1'b1);
      check_output("exp_hold_4", 1'b1, 2, 2);
      apply_stimulus(1'b1, 32'sd5, 4'd1, 1'b0, 1'b1);
      check_output("exp_next_1", 1'b0, 2, 2);
      apply_stimulus(1'b1, 32'sd6, 4'd1, 1'b0, 1'b1);
      check_output("exp_next_2", 1'b1, 5, 2);

      // decim_log2=15 clamps to 256-sample blocks
      for (int i = 0; i < 255; i++) begin
         apply_stimulus(1'b1, 32'(i), 4'd15, 1'b0, 1'b1);
         check_output("clamp_open", 1'b0, 5, 2);
      end
      apply_stimulus(1'b1, 32'sd255, 4'd15, 1'b0, 1'b1);
      check_output("clamp_close", 1'b1, 127, 2);
      apply_stimulus(1'b0, 32'sd0, 4'd15, 1'b0, 1'b1);

      // asynchronous reset mid-block with a pending result
      apply_stimulus(1'b1, 32'sd5, 4'd0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 32'sd6, 4'd0, 1'b0, 1'b0);
      check_output("pre_rst", 1'b1, 6, 3);
      apply_stimulus(1'b1, 32'sd7, 4'd2, 1'b0, 1'b0);
      #2;
      aresetn = 1'b0;
      model_reset();
      #1;
      check_output("async_rst", 1'b0, 0, 0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      apply_stimulus(1'b1, 32'sd20, 4'd2, 1'b0, 1'b1);
      apply_stimulus(1'b1, 32'sd21, 4'd2, 1'b0, 1'b1);
      apply_stimulus(1'b1, 32'sd22, 4'd2, 1'b0, 1'b1);
      check_output("post_rst_3", 1'b0, 0, 0);
      apply_stimulus(1'b1, 32'sd23, 4'd2, 1'b0, 1'b1);
      check_output("post_rst_4", 1'b1, 21, 0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic               r_vld;
         logic               r_clr;
         logic               r_rdy;
         logic [3:0]         r_dlog;
         logic signed [31:0] r_data;
         r_vld  = ($urandom_range(0, 3) != 0);
         r_clr  = ($urandom_range(0, 19) == 0);
         r_rdy  = $urandom_range(0, 1) == 1;
         r_dlog = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) r_data = $urandom;
         else r_data = 32'($urandom_range(0, 200)) - 32'sd100;
         apply_stimulus(r_vld, r_data, r_dlog, r_clr, r_rdy);
         check_output($sformatf("rand%0d", i), m_vld, m_data, m_over);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/axis_boxcar_decimator.md
AXIS_BOXCAR_DECIMATOR -- requirements
Module: axis_boxcar_decimator

Interface
REQ-001 SHALL have parameter S_AXIS_DATA_WIDTH, default 32: input sample width, signed.
REQ-002 SHALL have parameter M_AXIS_DATA_WIDTH, default 32: output sample width, signed; always equal to S_AXIS_DATA_WIDTH.
REQ-003 SHALL have parameter LOG2_NMAX, default 8: maximum decimation exponent.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, as fixed for this block.
REQ-005 SHALL have port aclk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port aresetn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port S_AXIS_tdata, input, S_AXIS_DATA_WIDTH bits: signed sample from the IIR stage.
REQ-008 SHALL have port S_AXIS_tvalid, input, 1 bit: sample valid; there is no S_AXIS_tready and every valid sample is consumed.
REQ-009 SHALL have port decim_log2, input, 4 bits: block length N = 2^decim_log2; values above LOG2_NMAX are clamped to LOG2_NMAX.
REQ-010 SHALL have port clear, input, 1 bit: synchronous flush of the block in progress.
REQ-011 SHALL have port M_AXIS_tdata, output, M_AXIS_DATA_WIDTH bits: block mean.
REQ-012 SHALL have port M_AXIS_tvalid, output, 1 bit: mean pending.
REQ-013 SHALL have port M_AXIS_tready, input, 1 bit: downstream accept.
REQ-014 SHALL have port overrun_count, output, 16 bits: count of unaccepted results replaced by newer ones.

Function
REQ-015 SHALL accept a sample on every rising edge where S_AXIS_tvalid=1 and clear=0.
REQ-016 SHALL keep an accumulator of S_AXIS_DATA_WIDTH+LOG2_NMAX bits, signed and sign-extended, so that no overflow is possible at the maximum N.
REQ-017 SHALL keep a sample counter of LOG2_NMAX+1 bits.
REQ-018 SHALL latch the clamped decim_log2 into a block register when the first sample of a block is accepted (counter=0); a decim_log2 change mid-block takes effect only from the next block.
REQ-019 SHALL, on an accepted sample that is not the last of its block, add the sample to the accumulator and increment the counter.
REQ-020 SHALL, on the accepted sample that makes counter+1 = N, load the output register with (accumulator + sample) arithmetically right-shifted by the block exponent (floor), then zero the accumulator and counter.
REQ-021 SHALL assert M_AXIS_tvalid=1 in the same load edge, giving a latency of 1 clock from presentation of the last sample to tvalid high.
REQ-022 SHALL pass samples through when decim_log2=0 (N=1): each valid sample appears on M_AXIS_tdata unchanged after 1 clock.
REQ-023 SHALL hold M_AXIS_tdata stable while M_AXIS_tvalid=1 and M_AXIS_tready=0, except as REQ-025 states.
REQ-024 SHALL complete the handshake at an edge where M_AXIS_tvalid=1 and M_AXIS_tready=1; tvalid then drops to 0 unless a load occurs at the same edge.
REQ-025 SHALL, on a load while tvalid=1 and tready=0, replace the pending data with the new result, keep tvalid at 1, and increment overrun_count, saturating at 0xFFFF.
REQ-026 SHALL, on a load while tvalid=1 and tready=1, hand over the old data, load the new data and keep tvalid at 1, without counting an overrun.
REQ-027 SHALL, when clear=1, zero the accumulator and counter and discard any sample presented in that cycle.
REQ-028 SHALL leave the pending output, tvalid and overrun_count unaffected by clear.
REQ-029 SHALL apply clear with priority over an accepted sample when both occur at the same edge.
REQ-030 SHALL hold the accumulator and counter when S_AXIS_tvalid=0; gaps in the input do not break a block.

Reset
REQ-031 SHALL, while aresetn=0 and independent of aclk, set the accumulator, counter, block exponent, M_AXIS_tdata and overrun_count to 0 and M_AXIS_tvalid to 0.
REQ-032 SHALL discard a partial block and any pending output when reset is asserted mid-operation.
REQ-033 SHALL start a new block with the first valid sample after reset release.

Verification
REQ-034 SHALL be verified by: decim_log2=2, tready=1, samples 4,8,12,16 on consecutive cycles -> a single tvalid pulse with tdata=10, one cycle after the 16 is presented.
REQ-035 SHALL be verified by: decim_log2=1, samples -3,-4 -> tdata=-4 (floor of -3.5); samples -3,-2 -> tdata=-3.
REQ-036 SHALL be verified by: decim_log2=0, tready=0, three valid samples 1,2,3 -> tdata=3, tvalid=1, overrun_count=2; then tready=1 for one cycle -> tvalid=0.
REQ-037 SHALL be verified by: decim_log2=3, 5 samples, then clear=1 together with a 6th sample, then 8 samples of 0x7FFFFFFF -> output 0x7FFFFFFF with no contribution from the earlier 5 samples.
REQ-038 SHALL be verified by: decim_log2 changed from 2 to 1 after the 2nd sample of a block -> that block still closes after 4 samples and the next closes after 2; decim_log2=15 -> blocks of 2^LOG2_NMAX=256 samples.
REQ-039 SHALL be verified by: aresetn pulsed low asynchronously mid-block with tvalid=1 -> tvalid=0, tdata=0 and overrun_count=0 immediately; the next full block is correct.
